// File: rtl/memory_256x8_pkg.sv
// Shared types and default geometry for the 256x8 single-port RAM.
package memory_256x8_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/memory_256x8_if.sv
// Access bus for the RAM: shared address, write data/enable, registered read data and ready.
interface memory_256x8_if #(
    parameter int unsigned DATA_WIDTH = memory_256x8_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = memory_256x8_pkg::ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q;
    logic                  ready;

    modport master (
        output address,
        output data,
        output wren,
        input  q,
        input  ready
    );

    modport slave (
        input  address,
        input  data,
        input  wren,
        output q,
        output ready
    );
endinterface

// File: rtl/memory_256x8_clear_ctrl.sv
// Post-reset clear sequencer: state, clear pointer, ready flag and the array write-port mux.
module memory_256x8_clear_ctrl
    import memory_256x8_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = memory_256x8_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = memory_256x8_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    input  logic [DATA_WIDTH-1:0] user_data,
    input  logic                  user_wren,
    output logic                  ready,
    output logic                  wr_en_c,
    output logic [ADDR_WIDTH-1:0] wr_addr_c,
    output logic [DATA_WIDTH-1:0] wr_data_c
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;

    // Walk every address once after reset, then hand the array to the user.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == LAST_ADDR) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Clear writes own the port during CLEAR; user inputs are ignored there.
    always_comb begin
        wr_en_c   = user_wren;
        wr_addr_c = user_addr;
        wr_data_c = user_data;
        if (state == CLEAR) begin
            wr_en_c   = 1'b1;
            wr_addr_c = ptr;
            wr_data_c = '0;
        end
    end

endmodule

// File: rtl/memory_256x8.sv
// 256x8 single-port synchronous RAM with write-through registered read and self-clear after reset.
module memory_256x8
    import memory_256x8_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = memory_256x8_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = memory_256x8_pkg::ADDR_WIDTH
) (
    input  logic           clock,
    input  logic           reset_n,
    memory_256x8_if.slave  bus
);

    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic                  ready;
    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [DATA_WIDTH-1:0] q;

    memory_256x8_clear_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clock     (clock),
        .reset_n   (reset_n),
        .user_addr (bus.address),
        .user_data (bus.data),
        .user_wren (bus.wren),
        .ready     (ready),
        .wr_en_c   (wr_en_c),
        .wr_addr_c (wr_addr_c),
        .wr_data_c (wr_data_c)
    );

    // Storage array: no reset so it maps onto a RAM macro.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Read port; a write returns the new data on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (!ready) begin
            q <= '0;
        end else if (bus.wren) begin
            q <= bus.data;
        end else begin
            q <= mem[bus.address];
        end
    end

    assign bus.q     = q;
    assign bus.ready = ready;

endmodule

// File: tb/tb_memory_256x8.sv
// Directed bench for memory_256x8: clear sequence, read/write, write-through, boundaries, reset.
module tb_memory_256x8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    memory_256x8_if bus ();

    memory_256x8 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one access at the falling edge, then sample just after the rising edge.
    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.wren    = w;
        bus.address = a;
        bus.data    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic run_clear(input string tag);
        for (int i = 1; i <= 256; i++) begin
            @(posedge clock);
            #1;
            if (i == 1 || i == 128 || i == 255) begin
                chk({tag, "_ready_low"}, 8'(bus.ready), 8'h00);
                chk({tag, "_q_zero"}, bus.q, 8'h00);
            end
        end
        chk({tag, "_ready_high"}, 8'(bus.ready), 8'h01);
        chk({tag, "_q_after"}, bus.q, 8'h00);
    endtask

    initial begin
        bus.wren    = 1'b1;
        bus.address = 8'h0F;
        bus.data    = 8'hEE;
        #12;
        chk("rst_q", bus.q, 8'h00);
        chk("rst_ready", 8'(bus.ready), 8'h00);

        // Release reset with a user write pending; it must be ignored during clear.
        @(negedge clock);
        reset_n = 1'b1;
        run_clear("clr1");
        bus.wren = 1'b0;

        access(1'b0, 8'h0F, 8'h00); chk("rd_0f_ignored", bus.q, 8'h00);
        access(1'b1, 8'h0F, 8'h02); chk("wr_0f", bus.q, 8'h02);
        access(1'b1, 8'h0E, 8'h03); chk("wr_0e", bus.q, 8'h03);
        access(1'b0, 8'h0F, 8'h00); chk("rd_0f", bus.q, 8'h02);
        access(1'b0, 8'h0E, 8'h00); chk("rd_0e", bus.q, 8'h03);
        access(1'b0, 8'hA5, 8'h00); chk("rd_a5_unwritten", bus.q, 8'h00);
        access(1'b1, 8'hFF, 8'hAB); chk("wr_ff", bus.q, 8'hAB);
        access(1'b1, 8'h00, 8'hCD); chk("wr_00", bus.q, 8'hCD);
        access(1'b0, 8'hFF, 8'h00); chk("rd_ff", bus.q, 8'hAB);
        access(1'b0, 8'h00, 8'h00); chk("rd_00", bus.q, 8'hCD);
        access(1'b1, 8'h10, 8'h5A); chk("wr_10_through", bus.q, 8'h5A);
        access(1'b0, 8'h10, 8'h00); chk("rd_10", bus.q, 8'h5A);
        access(1'b0, 8'h10, 8'h00); chk("rd_10_hold", bus.q, 8'h5A);
        access(1'b0, 8'h0F, 8'h00); chk("rd_0f_intact", bus.q, 8'h02);
        access(1'b0, 8'h11, 8'h00); chk("rd_11_neighbour", bus.q, 8'h00);
        access(1'b1, 8'h20, 8'h77); chk("wr_20", bus.q, 8'h77);
        access(1'b0, 8'h20, 8'h00); chk("rd_20", bus.q, 8'h77);

        // Asynchronous reset mid-run: outputs drop before any clock edge.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_q", bus.q, 8'h00);
        chk("midrst_ready", 8'(bus.ready), 8'h00);
        @(posedge clock);
        #1;
        chk("midrst_hold_q", bus.q, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        run_clear("clr2");

        access(1'b0, 8'h20, 8'h00); chk("rd_20_recleared", bus.q, 8'h00);
        access(1'b0, 8'h10, 8'h00); chk("rd_10_recleared", bus.q, 8'h00);
        access(1'b0, 8'hFF, 8'h00); chk("rd_ff_recleared", bus.q, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
